// File: rtl/switch_box_config_loader.sv
// Writer side of the fabric configuration scan chain: takes words from a
// valid/ready stream and shifts exactly CHAIN_LEN bits, LSB first, into the chain.
module switch_box_config_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WORD_W-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             cfg_out,
  output logic             cfg_en,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic [CNT_W-1:0] bits_sent
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C      = CNT_W'(0);

  // Bits to take from the next word; trims the final partial word so the
  // chain never sees more than CHAIN_LEN bits.
  function automatic logic [CNT_W-1:0] calc_nbits(input logic [CNT_W-1:0] sent);
    logic [31:0] remain;
    remain = 32'(CHAIN_LEN) - 32'(sent);
    if (remain < 32'(WORD_W)) begin
      calc_nbits = CNT_W'(remain);
    end else begin
      calc_nbits = CNT_W'(WORD_W);
    end
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WORD_W-1:0] shreg_r;
  logic [WORD_W-1:0] shreg_nxt_s;
  logic [CNT_W-1:0]  bits_sent_r;
  logic [CNT_W-1:0]  sent_nxt_s;
  logic [CNT_W-1:0]  wcnt_r;
  logic [CNT_W-1:0]  wcnt_nxt_s;
  logic [CNT_W-1:0]  nbits_r;
  logic [CNT_W-1:0]  nbits_nxt_s;
  logic              s_ready_r;
  logic              cfg_out_r;
  logic              cfg_en_r;
  logic              cfg_busy_r;
  logic              cfg_done_r;

  // Next-state and datapath update for the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    sent_nxt_s  = bits_sent_r;
    wcnt_nxt_s  = wcnt_r;
    nbits_nxt_s = nbits_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = ST_LOAD;
          sent_nxt_s  = ZERO_C;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_LOAD: begin
        if (s_valid && s_ready_r) begin
          state_nxt_s = ST_SHIFT;
          shreg_nxt_s = s_data;
          nbits_nxt_s = calc_nbits(bits_sent_r);
          wcnt_nxt_s  = ZERO_C;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SHIFT: begin
        shreg_nxt_s = {1'b0, shreg_r[WORD_W-1:1]};
        sent_nxt_s  = bits_sent_r + ONE_C;
        wcnt_nxt_s  = wcnt_r + ONE_C;
        // Last bit of this word leaves on this edge
        if (wcnt_r == (nbits_r - ONE_C)) begin
          if ((bits_sent_r + ONE_C) == CHAIN_LEN_C) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {WORD_W{1'b0}};
      bits_sent_r <= ZERO_C;
      wcnt_r      <= ZERO_C;
      nbits_r     <= ZERO_C;
      s_ready_r   <= 1'b0;
      cfg_out_r   <= 1'b0;
      cfg_en_r    <= 1'b0;
      cfg_busy_r  <= 1'b0;
      cfg_done_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shreg_r     <= shreg_nxt_s;
      bits_sent_r <= sent_nxt_s;
      wcnt_r      <= wcnt_nxt_s;
      nbits_r     <= nbits_nxt_s;
      s_ready_r   <= (state_nxt_s == ST_LOAD);
      cfg_en_r    <= (state_nxt_s == ST_SHIFT);
      // Gate the serial bit so stale shift-register contents never leak out
      cfg_out_r   <= (state_nxt_s == ST_SHIFT) ? shreg_nxt_s[0] : 1'b0;
      cfg_busy_r  <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_SHIFT);
      cfg_done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  assign s_ready   = s_ready_r;
  assign cfg_out   = cfg_out_r;
  assign cfg_en    = cfg_en_r;
  assign cfg_busy  = cfg_busy_r;
  assign cfg_done  = cfg_done_r;
  assign bits_sent = bits_sent_r;

endmodule
